// File: rtl/param_pattern_generator.sv
// Raster test-pattern source: streams H_ACTIVE x V_ACTIVE pixels over Valid/Ready with
// selectable pattern, frame/line markers and a completed-frame counter.
module param_pattern_generator #(
  parameter int unsigned H_ACTIVE    = 800,
  parameter int unsigned V_ACTIVE    = 600,
  parameter int unsigned PIXEL_W     = 8,
  parameter int unsigned CHECK_LOG2  = 5,
  parameter int unsigned FC_W        = 8,
  parameter logic [3*PIXEL_W-1:0] SOLID_COLOR = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 Enable,
  input  logic [1:0]           Mode,
  input  logic                 VideoReady,
  output logic                 VideoValid,
  output logic [3*PIXEL_W-1:0] Video,
  output logic                 FrameStart,
  output logic                 LineEnd,
  output logic [FC_W-1:0]      FrameCount
);

  localparam int unsigned BAR_W = H_ACTIVE / 8;
  localparam int unsigned W_HV  = ($clog2(H_ACTIVE) > $clog2(V_ACTIVE)) ?
                                  $clog2(H_ACTIVE) : $clog2(V_ACTIVE);
  localparam int unsigned W_PC  = (PIXEL_W > CHECK_LOG2 + 1) ? PIXEL_W : CHECK_LOG2 + 1;
  // Coordinates are wide enough for the checker/gradient bit selects as well as the raster.
  localparam int unsigned CW    = (W_HV > W_PC) ? W_HV : W_PC;
  localparam int unsigned BCW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PIXEL_W-1:0] CH_F = '1;
  localparam logic [PIXEL_W-1:0] CH_Z = '0;

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e               r_state;
  logic [CW-1:0]        r_x, r_y;
  logic [BCW-1:0]       r_bar_cnt;
  logic [2:0]           r_bar_idx;
  logic [FC_W-1:0]      r_fc;
  logic [1:0]           r_mode;
  logic [3*PIXEL_W-1:0] r_video;
  logic                 r_fs, r_le;

  logic                 w_xfer, w_present, w_last_x, w_last_y, w_first;
  logic [CW-1:0]        w_px, w_py;
  logic [BCW-1:0]       w_pcnt;
  logic [2:0]           w_pidx;
  logic [FC_W-1:0]      w_fc;
  logic [1:0]           w_mode;
  logic [PIXEL_W+FC_W-1:0] w_fc_ext;
  logic [3*PIXEL_W-1:0] w_video;

  // w_p* describe the pixel to present next: the advanced position on a transfer,
  // otherwise the stored one (idle restart resumes where the stream stopped).
  always_comb begin
    w_xfer    = (r_state == StActive) && VideoReady;
    w_present = Enable && ((r_state == StIdle) || VideoReady);
    w_last_x  = (r_x == CW'(H_ACTIVE - 1));
    w_last_y  = (r_y == CW'(V_ACTIVE - 1));
    w_px      = r_x;
    w_py      = r_y;
    w_pcnt    = r_bar_cnt;
    w_pidx    = r_bar_idx;
    w_fc      = r_fc;
    if (w_xfer) begin
      if (w_last_x) begin
        w_px   = '0;
        w_pcnt = '0;
        w_pidx = '0;
        w_py   = w_last_y ? '0 : r_y + 1'b1;
        if (w_last_y) w_fc = r_fc + 1'b1;
      end else begin
        w_px = r_x + 1'b1;
        if (r_bar_cnt == BCW'(BAR_W - 1)) begin
          w_pcnt = '0;
          w_pidx = r_bar_idx + 1'b1;
        end else begin
          w_pcnt = r_bar_cnt + 1'b1;
        end
      end
    end
    w_first  = (w_px == '0) && (w_py == '0);
    w_mode   = w_first ? Mode : r_mode;
    w_fc_ext = {{PIXEL_W{1'b0}}, w_fc};
  end

  always_comb begin
    w_video = '0;
    unique case (w_mode)
      2'd0: w_video = SOLID_COLOR;
      2'd1: begin
        unique case (w_pidx)
          3'd0: w_video = {CH_F, CH_F, CH_F};
          3'd1: w_video = {CH_F, CH_F, CH_Z};
          3'd2: w_video = {CH_Z, CH_F, CH_F};
          3'd3: w_video = {CH_Z, CH_F, CH_Z};
          3'd4: w_video = {CH_F, CH_Z, CH_F};
          3'd5: w_video = {CH_F, CH_Z, CH_Z};
          3'd6: w_video = {CH_Z, CH_Z, CH_F};
          3'd7: w_video = {CH_Z, CH_Z, CH_Z};
        endcase
      end
      2'd2: w_video = (w_px[CHECK_LOG2] ^ w_py[CHECK_LOG2]) ? {CH_F, CH_F, CH_F} : '0;
      2'd3: w_video = {w_px[PIXEL_W-1:0], w_py[PIXEL_W-1:0], w_fc_ext[PIXEL_W-1:0]};
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_x       <= '0;
      r_y       <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_fc      <= '0;
      r_mode    <= '0;
      r_video   <= '0;
      r_fs      <= 1'b0;
      r_le      <= 1'b0;
    end else begin
      r_x       <= w_px;
      r_y       <= w_py;
      r_bar_cnt <= w_pcnt;
      r_bar_idx <= w_pidx;
      r_fc      <= w_fc;
      if (w_present) begin
        r_state <= StActive;
        r_mode  <= w_mode;
        r_video <= w_video;
        r_fs    <= w_first;
        r_le    <= (w_px == CW'(H_ACTIVE - 1));
      end else if (w_xfer) begin
        r_state <= StIdle;
        r_fs    <= 1'b0;
        r_le    <= 1'b0;
      end
    end
  end

  assign VideoValid = (r_state == StActive);
  assign Video      = r_video;
  assign FrameStart = r_fs;
  assign LineEnd    = r_le;
  assign FrameCount = r_fc;

endmodule

// File: tb/tb_param_pattern_generator.sv
// Self-checking bench for param_pattern_generator: constant vectors, a pixel-index
// reference model, randomized Ready/Mode/Enable and reset corner cases.
module tb_param_pattern_generator;

  localparam int H = 16;
  localparam int V = 4;
  localparam int PW = 8;
  localparam int CL = 2;
  localparam int FCW = 4;
  localparam logic [23:0] SOLID = 24'hA55A3C;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        Enable = 1'b0;
  logic [1:0]  Mode = 2'd0;
  logic        VideoReady = 1'b0;
  logic        VideoValid;
  logic [23:0] Video;
  logic        FrameStart;
  logic        LineEnd;
  logic [3:0]  FrameCount;

  always #5 clock = ~clock;

  param_pattern_generator #(
    .H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_W(PW), .CHECK_LOG2(CL), .FC_W(FCW),
    .SOLID_COLOR(SOLID)
  ) u_dut (
    .clock(clock), .reset(reset), .Enable(Enable), .Mode(Mode),
    .VideoReady(VideoReady), .VideoValid(VideoValid), .Video(Video),
    .FrameStart(FrameStart), .LineEnd(LineEnd), .FrameCount(FrameCount)
  );

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp, n_err;
  bit   m_valid;
  int   m_p, m_fc, m_mode;
  int   d_xfers, d_fs, d_le;

  function automatic logic [23:0] ref_pix(input int mode, input int p, input int fc);
    int x, y;
    x = p % H;
    y = p / H;
    case (mode)
      0: return SOLID;
      1: begin
        case (x / (H / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      2: return (((x >> CL) & 1) != ((y >> CL) & 1)) ? 24'hFFFFFF : 24'h000000;
      default: return {8'(x % 256), 8'(y % 256), 8'(fc % 256)};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_p     = 0;
    m_fc    = 0;
    m_mode  = 0;
  endtask

  // One clock: advance the model from the driven inputs, then compare every output.
  task automatic cyc();
    bit xf, pr;
    xf = m_valid && VideoReady;
    pr = Enable && (!m_valid || VideoReady);
    if (VideoValid && VideoReady) d_xfers++;
    if (xf) begin
      m_p++;
      if (m_p == H * V) begin
        m_p  = 0;
        m_fc = (m_fc + 1) % 16;
      end
    end
    if (pr) begin
      m_valid = 1'b1;
      if (m_p == 0) m_mode = int'(Mode);
    end else if (xf) begin
      m_valid = 1'b0;
    end
    @(posedge clock);
    #1;
    chk("valid", 32'(VideoValid), 32'(m_valid));
    chk("fcount", 32'(FrameCount), 32'(m_fc));
    if (m_valid) begin
      chk("video", 32'(Video), 32'(ref_pix(m_mode, m_p, m_fc)));
      chk("fstart", 32'(FrameStart), 32'(m_p == 0));
      chk("lend", 32'(LineEnd), 32'((m_p % H) == H - 1));
      if (FrameStart) d_fs++;
      if (LineEnd) d_le++;
    end else begin
      chk("fs_idle", 32'(FrameStart), 32'd0);
      chk("le_idle", 32'(LineEnd), 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit          pv, pr;
    logic [23:0] pvid;
    int          budget;
    n_cmp = 0;
    n_err = 0;
    d_xfers = 0;
    model_reset();

    vecs.push_back('{2'd1, 0, 0, 24'hFFFFFF});
    vecs.push_back('{2'd1, 1, 0, 24'hFFFFFF});
    vecs.push_back('{2'd1, 2, 0, 24'hFFFF00});
    vecs.push_back('{2'd1, 5, 1, 24'h00FFFF});
    vecs.push_back('{2'd1, 7, 2, 24'h00FF00});
    vecs.push_back('{2'd1, 9, 0, 24'hFF00FF});
    vecs.push_back('{2'd1, 10, 3, 24'hFF0000});
    vecs.push_back('{2'd1, 13, 0, 24'h0000FF});
    vecs.push_back('{2'd1, 15, 3, 24'h000000});
    vecs.push_back('{2'd2, 0, 0, 24'h000000});
    vecs.push_back('{2'd2, 3, 1, 24'h000000});
    vecs.push_back('{2'd2, 4, 0, 24'hFFFFFF});
    vecs.push_back('{2'd2, 8, 2, 24'h000000});
    vecs.push_back('{2'd2, 12, 3, 24'hFFFFFF});
    vecs.push_back('{2'd3, 5, 2, 24'h050200});
    vecs.push_back('{2'd3, 15, 3, 24'h0F0300});
    vecs.push_back('{2'd0, 7, 1, 24'hA55A3C});

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(VideoValid), 32'd0);
    chk("rst_video", 32'(Video), 32'd0);
    chk("rst_fc", 32'(FrameCount), 32'd0);
    chk("rst_fs", 32'(FrameStart), 32'd0);
    chk("rst_le", 32'(LineEnd), 32'd0);

    // Constant vectors: pixel (x,y) of frame 0 with Ready held high
    foreach (vecs[i]) begin
      do_reset();
      Mode = vecs[i].mode;
      Enable = 1'b1;
      VideoReady = 1'b1;
      repeat (vecs[i].y * H + vecs[i].x + 1) cyc();
      chk("vec", 32'(Video), 32'(vecs[i].exp));
    end

    // Colour bars, two frames: marker counts
    do_reset();
    Mode = 2'd1;
    d_fs = 0;
    d_le = 0;
    repeat (2 * H * V) cyc();
    chk("fs_count", 32'(d_fs), 32'd2);
    chk("le_count", 32'(d_le), 32'd8);

    // Checkerboard full frame
    do_reset();
    Mode = 2'd2;
    repeat (H * V) cyc();

    // Gradient over 17 frames with FrameCount wrap
    do_reset();
    Mode = 2'd3;
    repeat (15 * H * V + 1) cyc();
    chk("fc_15", 32'(FrameCount), 32'd15);
    repeat (H * V) cyc();
    chk("fc_wrap", 32'(FrameCount), 32'd0);
    chk("wrap_fs", 32'(FrameStart), 32'd1);
    repeat (H * V) cyc();

    // Random Ready and Mode over 3 frames, with hold-stability checks
    do_reset();
    Enable = 1'b1;
    d_xfers = 0;
    budget = 0;
    while (d_xfers < 3 * H * V && budget < 4000) begin
      VideoReady = 1'($urandom % 2);
      Mode = 2'($urandom % 4);
      pv = VideoValid;
      pr = VideoReady;
      pvid = Video;
      cyc();
      if (pv && !pr) chk("hold", 32'(Video), 32'(pvid));
      budget++;
    end
    chk("t4_xfers", 32'(d_xfers), 32'(3 * H * V));
    // Random Enable as well
    repeat (400) begin
      VideoReady = 1'($urandom % 2);
      Mode = 2'($urandom % 4);
      Enable = ($urandom % 8) != 0;
      cyc();
    end

    // Mode change mid-frame, Enable drop with a pending pixel, resume
    do_reset();
    Mode = 2'd1;
    Enable = 1'b1;
    VideoReady = 1'b1;
    repeat (31) cyc();
    Mode = 2'd2;
    repeat (10) cyc();
    VideoReady = 1'b0;
    Enable = 1'b0;
    repeat (3) cyc();
    chk("p40_held", 32'(Video), 32'h00FF00FF);
    chk("p40_valid", 32'(VideoValid), 32'd1);
    VideoReady = 1'b1;
    cyc();
    chk("drop_valid", 32'(VideoValid), 32'd0);
    repeat (3) cyc();
    Enable = 1'b1;
    cyc();
    chk("resume41", 32'(Video), 32'h00FF00FF);
    cyc();
    chk("resume42", 32'(Video), 32'h00FF0000);
    repeat (21 + 5) cyc();
    chk("mode_next", 32'(Video), 32'h00FFFFFF);

    // Asynchronous reset mid-line
    do_reset();
    Mode = 2'd3;
    repeat (75) cyc();
    #3;
    reset = 1'b0;
    #1;
    chk("async_valid", 32'(VideoValid), 32'd0);
    chk("async_video", 32'(Video), 32'd0);
    chk("async_fc", 32'(FrameCount), 32'd0);
    chk("async_fs", 32'(FrameStart), 32'd0);
    chk("async_le", 32'(LineEnd), 32'd0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    cyc();
    chk("restart_fs", 32'(FrameStart), 32'd1);
    chk("restart_video", 32'(Video), 32'd0);
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
